// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS CPU datapath.
package mips_cpu_pkg;

    localparam int IM_AW = 11;

    typedef logic [31:0]      inst_t;
    typedef logic [IM_AW-1:0] im_addr_t;
    typedef logic [31:0]      pc_t;

    localparam pc_t RESET_PC = 32'h0000_0000;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, drives the synchronous-read instruction memory,
// and pairs each returned word with the PC it was fetched from.
//
// state | meaning
// RUN   | fetching one word per non-stalled cycle
// FAULT | misaligned PC reported; idle until a redirect
module if_stage
    import mips_cpu_pkg::*;
#(
    parameter int  IM_AW    = mips_cpu_pkg::IM_AW,
    parameter pc_t RESET_PC = mips_cpu_pkg::RESET_PC
) (
    input  logic             cpu_clk_50M,
    input  logic             cpu_rst_n,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [IM_AW-1:0] imaddr,
    output logic             imce,
    input  logic [31:0]      inst_i,
    output logic             if_valid,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_pc_plus4,
    output logic [31:0]      if_inst,
    output logic             if_adel
);

    fetch_state_e state_q, state_d;
    pc_t          pc_q, pc_d;
    pc_t          resp_pc_q, resp_pc_d;
    logic         resp_valid_q, resp_valid_d;
    logic         resp_adel_q, resp_adel_d;
    logic         fetch_en;
    logic         pc_aligned;

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            resp_valid_q <= 1'b0;
            resp_adel_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            resp_pc_q    <= resp_pc_d;
            resp_valid_q <= resp_valid_d;
            resp_adel_q  <= resp_adel_d;
        end
    end

    assign pc_aligned = (pc_q[1:0] == 2'b00);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        resp_pc_d    = resp_pc_q;
        resp_valid_d = resp_valid_q;
        resp_adel_d  = resp_adel_q;
        fetch_en     = 1'b0;

        // A redirect still reads memory at the old PC when not stalled; that word is dropped.
        if (!stall && state_q == RUN && pc_aligned) begin
            fetch_en = 1'b1;
        end

        if (redirect_valid) begin
            pc_d         = redirect_pc;
            resp_valid_d = 1'b0;
            resp_adel_d  = 1'b0;
            state_d      = RUN;
        end else if (!stall) begin
            case (state_q)
                RUN: begin
                    resp_valid_d = 1'b1;
                    resp_pc_d    = pc_q;
                    if (pc_aligned) begin
                        pc_d        = pc_q + 32'd4;
                        resp_adel_d = 1'b0;
                    end else begin
                        resp_adel_d = 1'b1;
                        state_d     = FAULT;
                    end
                end
                FAULT: begin
                    resp_valid_d = 1'b0;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    assign imce        = fetch_en & cpu_rst_n;
    assign imaddr      = pc_q[IM_AW+1:2];
    assign if_valid    = resp_valid_q;
    assign if_pc       = resp_pc_q;
    assign if_pc_plus4 = resp_pc_q + 32'd4;
    assign if_adel     = resp_adel_q;
    assign if_inst     = (resp_valid_q && !resp_adel_q) ? inst_i : 32'h0000_0000;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a behavioural synchronous-read memory.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic [10:0] imaddr;
    logic        imce;
    logic [31:0] inst_i = 32'h0;
    logic        if_valid, if_adel;
    logic [31:0] if_pc, if_pc_plus4, if_inst;

    logic [10:0] imaddr2;
    logic        imce2;
    logic [31:0] inst2 = 32'h0;
    logic        if_valid2, if_adel2;
    logic [31:0] if_pc2, if_pc_plus4_2, if_inst2;

    int errors = 0;
    int checks = 0;

    always #10 clk = ~clk;

    if_stage #(.IM_AW(11), .RESET_PC(32'h0000_0000)) dut (
        .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imaddr(imaddr), .imce(imce), .inst_i(inst_i),
        .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
        .if_inst(if_inst), .if_adel(if_adel)
    );

    if_stage #(.IM_AW(11), .RESET_PC(32'h0000_2000)) dut2 (
        .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .stall(1'b0),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imaddr(imaddr2), .imce(imce2), .inst_i(inst2),
        .if_valid(if_valid2), .if_pc(if_pc2), .if_pc_plus4(if_pc_plus4_2),
        .if_inst(if_inst2), .if_adel(if_adel2)
    );

    // Memory word at address a holds 0xC0DE0000 + a.
    always @(posedge clk) begin
        if (imce)  inst_i <= 32'hC0DE_0000 | {21'h0, imaddr};
        if (imce2) inst2  <= 32'hC0DE_0000 | {21'h0, imaddr2};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_imce", {31'h0, imce}, 32'h0);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_adel", {31'h0, if_adel}, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_pc4", if_pc_plus4, 32'h4);
        chk("rst_imaddr", {21'h0, imaddr}, 32'h0);
        chk("rst2_imaddr_alias", {21'h0, imaddr2}, 32'h0);
        chk("rst2_pc", if_pc2, 32'h2000);
        chk("rst2_imce", {31'h0, imce2}, 32'h0);

        rst_n = 1'b1;
        #1;
        chk("run_imce0", {31'h0, imce}, 32'h1);
        tick();
        chk("run0_valid", {31'h0, if_valid}, 32'h1);
        chk("run0_pc", if_pc, 32'h0);
        chk("run0_inst", if_inst, 32'hC0DE_0000);
        chk("run2_pc", if_pc2, 32'h2000);
        chk("run2_inst", if_inst2, 32'hC0DE_0000);
        chk("run2_valid", {31'h0, if_valid2}, 32'h1);
        tick();
        chk("run1_pc", if_pc, 32'h4);
        chk("run1_inst", if_inst, 32'hC0DE_0001);
        tick();
        chk("run2_pc8", if_pc, 32'h8);
        chk("run2_inst8", if_inst, 32'hC0DE_0002);

        stall = 1'b1;
        #1;
        chk("stall_imce", {31'h0, imce}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", if_pc, 32'h8);
            chk("stall_inst", if_inst, 32'hC0DE_0002);
            chk("stall_valid", {31'h0, if_valid}, 32'h1);
            chk("stall_imce_held", {31'h0, imce}, 32'h0);
        end
        stall = 1'b0;
        #1;
        chk("unstall_imce", {31'h0, imce}, 32'h1);
        chk("unstall_imaddr", {21'h0, imaddr}, 32'h3);
        tick();
        chk("unstall_pc", if_pc, 32'hC);
        chk("unstall_inst", if_inst, 32'hC0DE_0003);

        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        chk("redir_bubble_valid", {31'h0, if_valid}, 32'h0);
        chk("redir_bubble_inst", if_inst, 32'h0);
        chk("redir_imaddr", {21'h0, imaddr}, 32'h10);
        tick();
        chk("redir_pc", if_pc, 32'h40);
        chk("redir_pc4", if_pc_plus4, 32'h44);
        chk("redir_inst", if_inst, 32'hC0DE_0010);
        chk("redir_valid", {31'h0, if_valid}, 32'h1);

        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        stall = 1'b1;
        #1;
        chk("rs_imce", {31'h0, imce}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        chk("rs_valid", {31'h0, if_valid}, 32'h0);
        chk("rs_pcq", {21'h0, imaddr}, 32'h40);
        for (int i = 0; i < 2; i++) begin
            chk("rs_stall_imce", {31'h0, imce}, 32'h0);
            tick();
            chk("rs_stall_valid", {31'h0, if_valid}, 32'h0);
            chk("rs_stall_imaddr", {21'h0, imaddr}, 32'h40);
        end
        stall = 1'b0;
        #1;
        chk("rs_release_imce", {31'h0, imce}, 32'h1);
        tick();
        chk("rs_pc", if_pc, 32'h100);
        chk("rs_inst", if_inst, 32'hC0DE_0040);

        redirect_valid = 1'b1;
        redirect_pc = 32'h42;
        tick();
        redirect_valid = 1'b0;
        chk("mis_bubble", {31'h0, if_valid}, 32'h0);
        chk("mis_imce", {31'h0, imce}, 32'h0);
        tick();
        chk("mis_valid", {31'h0, if_valid}, 32'h1);
        chk("mis_adel", {31'h0, if_adel}, 32'h1);
        chk("mis_pc", if_pc, 32'h42);
        chk("mis_inst", if_inst, 32'h0);
        chk("fault_imce", {31'h0, imce}, 32'h0);
        tick();
        chk("fault_valid_a", {31'h0, if_valid}, 32'h0);
        tick();
        chk("fault_valid_b", {31'h0, if_valid}, 32'h0);
        chk("fault_inst", if_inst, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        #1;
        chk("fault_redir_imce", {31'h0, imce}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        chk("recov_bubble", {31'h0, if_valid}, 32'h0);
        chk("recov_adel", {31'h0, if_adel}, 32'h0);
        chk("recov_imce", {31'h0, imce}, 32'h1);
        chk("recov_imaddr", {21'h0, imaddr}, 32'h20);
        tick();
        chk("recov_pc", if_pc, 32'h80);
        chk("recov_inst", if_inst, 32'hC0DE_0020);
        chk("recov_adel2", {31'h0, if_adel}, 32'h0);

        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_imaddr", {21'h0, imaddr}, 32'h7FF);
        tick();
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", if_pc_plus4, 32'h0);
        chk("wrap_inst", if_inst, 32'hC0DE_07FF);
        chk("wrap_next_imaddr", {21'h0, imaddr}, 32'h0);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'h0, if_valid}, 32'h0);
        chk("mid_rst_imce", {31'h0, imce}, 32'h0);
        chk("mid_rst_pc", if_pc, 32'h0);
        chk("mid_rst_inst", if_inst, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_pc", if_pc, 32'h0);
        chk("post_rst_inst", if_inst, 32'hC0DE_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
